toll_datapath: RTL and testbench

Datapath stage directly downstream of the entry/exit sequencing controller. It consumes the controller's one-hot command strobes (`init`, `count`, `cal`, `up`, `down`, `en`, `dis`) and produces:
- the parking-time measurement and the fee result, via a multi-cycle shift-add multiplier;
- the saturating vehicle-occupancy count `num_veh`, which feeds back to the controller;
- the barrier state and the `done` completion pulse.

---
 rtl/toll_datapath_pkg.sv | 9 +
 rtl/tick_prescaler.sv | 22 ++
 rtl/toll_datapath.sv | 125 ++++++++++++
 tb/tb_toll_datapath.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/toll_datapath_pkg.sv
// Shared definitions for the toll controller/datapath pair: FSM encoding,
// occupancy width and default fee constants.
package toll_datapath_pkg;
   typedef enum logic [1:0] {IDLE, MUL, DONE} toll_state_e;

   localparam int OCC_W       = 2;
   localparam int RATE_DEF    = 20;
   localparam int MIN_FEE_DEF = 10;
endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by TICK_DIV while enabled; tick marks the cycle the count wraps.
module tick_prescaler #(
   parameter int TICK_DIV = 1000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic tick
);
   localparam int CW = $clog2(TICK_DIV);

   logic [CW-1:0] cnt;

   assign tick = en && !clr && (cnt == CW'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  cnt <= '0;
      else if (clr)  cnt <= '0;
      else if (en)   cnt <= tick ? '0 : cnt + 1'b1;
   end
endmodule

// File: rtl/toll_datapath.sv
// Toll datapath: parking-time counter, serial shift-add fee multiplier,
// saturating occupancy counter and barrier state.
module toll_datapath
   import toll_datapath_pkg::*;
#(
   parameter int TICK_DIV = 1000,
   parameter int TIME_W   = 16,
   parameter int FEE_W    = 16,
   parameter int RATE     = RATE_DEF,
   parameter int MIN_FEE  = MIN_FEE_DEF,
   parameter int CAPACITY = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              init,
   input  logic              count,
   input  logic              cal,
   input  logic              up,
   input  logic              down,
   input  logic              en,
   input  logic              dis,
   output logic [OCC_W-1:0]  num_veh,
   output logic              full,
   output logic [TIME_W-1:0] elapsed,
   output logic [FEE_W-1:0]  fee,
   output logic              fee_valid,
   output logic              done,
   output logic              busy,
   output logic              gate_open
);
   localparam int ACC_W = TIME_W + FEE_W;
   localparam int IDX_W = $clog2(TIME_W);

   toll_state_e       state;
   logic [TIME_W-1:0] opnd;
   logic [ACC_W-1:0]  acc, acc_nxt;
   logic [IDX_W-1:0]  idx;
   logic [FEE_W-1:0]  fee_sat;
   logic              tick;
   logic [OCC_W-1:0]  num_nxt;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (init),
      .en      (count),
      .tick    (tick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                       elapsed <= '0;
      else if (init)                      elapsed <= '0;
      else if (tick && !(&elapsed))       elapsed <= elapsed + 1'b1;
   end

   always_comb begin
      acc_nxt = acc;
      if (opnd[idx]) acc_nxt = acc + (ACC_W'(RATE) << idx);
      fee_sat = (|acc_nxt[ACC_W-1:FEE_W]) ? '1 : acc_nxt[FEE_W-1:0];
   end

   // Result is published on the last MUL edge so done/fee land together in DONE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         opnd      <= '0;
         acc       <= '0;
         idx       <= '0;
         fee       <= '0;
         fee_valid <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (cal) begin
               opnd      <= elapsed;
               acc       <= ACC_W'(MIN_FEE);
               idx       <= '0;
               fee_valid <= 1'b0;
               busy      <= 1'b1;
               state     <= MUL;
            end
            MUL: begin
               acc <= acc_nxt;
               idx <= idx + 1'b1;
               if (idx == IDX_W'(TIME_W - 1)) begin
                  fee       <= fee_sat;
                  fee_valid <= 1'b1;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      num_nxt = num_veh;
      if (up && !down && num_veh != OCC_W'(CAPACITY)) num_nxt = num_veh + 1'b1;
      if (down && !up && num_veh != '0)               num_nxt = num_veh - 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         num_veh <= '0;
         full    <= 1'b0;
      end else begin
         num_veh <= num_nxt;
         full    <= (num_nxt == OCC_W'(CAPACITY));
      end
   end

   // A full lot keeps the barrier shut unless a vehicle leaves in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   gate_open <= 1'b0;
      else if (dis)   gate_open <= 1'b0;
      else if (en)    gate_open <= !(full && !down);
   end
endmodule

// File: tb/tb_toll_datapath.sv
// Directed bench for toll_datapath with small parameters (TICK_DIV=4, TIME_W=8, FEE_W=12).
module tb_toll_datapath;
   logic        clk = 1'b0, reset_n = 1'b0;
   logic        init = 0, count = 0, cal = 0, up = 0, down = 0, en = 0, dis = 0;
   logic [1:0]  num_veh;
   logic        full, fee_valid, done, busy, gate_open;
   logic [7:0]  elapsed;
   logic [11:0] fee;

   int nchk = 0, npass = 0;
   int lat, ndone;

   toll_datapath #(
      .TICK_DIV(4), .TIME_W(8), .FEE_W(12), .RATE(20), .MIN_FEE(10), .CAPACITY(3)
   ) dut (
      .clk(clk), .reset_n(reset_n), .init(init), .count(count), .cal(cal),
      .up(up), .down(down), .en(en), .dis(dis), .num_veh(num_veh), .full(full),
      .elapsed(elapsed), .fee(fee), .fee_valid(fee_valid), .done(done),
      .busy(busy), .gate_open(gate_open)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got === exp) npass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Pulse cal, then watch win cycles; lat counts cycles from the cal cycle.
   task automatic cal_watch(input int win, output int l, output int nd);
      l = -1; nd = 0;
      cal = 1; step(); cal = 0;
      for (int k = 1; k <= win; k++) begin
         step();
         if (done) begin
            nd++;
            if (l < 0) l = k + 1;
         end
      end
   endtask

   task automatic pulse(input logic u, input logic d, input logic e, input logic s);
      up = u; down = d; en = e; dis = s;
      step();
      up = 0; down = 0; en = 0; dis = 0;
   endtask

   initial begin
      step(2);
      reset_n = 1;
      step(10);
      check("rst num_veh", num_veh, 0);
      check("rst full", full, 0);
      check("rst elapsed", elapsed, 0);
      check("rst fee", fee, 0);
      check("rst fee_valid", fee_valid, 0);
      check("rst done", done, 0);
      check("rst busy", busy, 0);
      check("rst gate", gate_open, 0);

      cal_watch(12, lat, ndone);
      check("base latency", lat, 9);
      check("base fee", fee, 10);
      check("base valid", fee_valid, 1);

      count = 1; step(20); count = 0;
      check("elapsed 20cyc", elapsed, 5);
      cal = 1; step(); cal = 0;
      check("busy after cal", busy, 1);
      check("valid cleared", fee_valid, 0);
      lat = -1; ndone = 0;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (done) begin ndone++; if (lat < 0) lat = k + 1; end
      end
      check("fee5 latency", lat, 9);
      check("fee5 ndone", ndone, 1);
      check("fee5 fee", fee, 110);
      check("fee5 valid", fee_valid, 1);
      check("busy idle", busy, 0);

      count = 1; step(1100); count = 0;
      check("elapsed sat", elapsed, 255);
      cal_watch(12, lat, ndone);
      check("sat fee", fee, 4095);
      init = 1; step(); init = 0;
      check("init clears", elapsed, 0);

      count = 1; step(8); count = 0;
      check("elapsed 2", elapsed, 2);
      cal = 1; step(); cal = 0;
      init = 1;
      lat = -1; ndone = 0;
      for (int k = 1; k <= 14; k++) begin
         cal = (k == 3);
         step();
         if (done) begin ndone++; if (lat < 0) lat = k + 1; end
      end
      cal = 0; init = 0;
      check("init mid elapsed", elapsed, 0);
      check("captured fee", fee, 50);
      check("recal ndone", ndone, 1);
      check("recal latency", lat, 9);

      pulse(1, 0, 0, 0); check("up1", num_veh, 1);
      pulse(1, 0, 0, 0); check("up2", num_veh, 2);
      check("not full at 2", full, 0);
      pulse(1, 0, 0, 0); check("up3", num_veh, 3);
      check("full at 3", full, 1);
      pulse(1, 0, 0, 0); check("up sat", num_veh, 3);
      pulse(1, 1, 0, 0); check("up+down", num_veh, 3);
      pulse(0, 1, 0, 0); check("down1", num_veh, 2);
      check("full clr", full, 0);
      pulse(0, 1, 0, 0); check("down2", num_veh, 1);
      pulse(0, 1, 0, 0); check("down3", num_veh, 0);
      pulse(0, 1, 0, 0); check("down sat", num_veh, 0);

      pulse(0, 0, 1, 1); check("en+dis", gate_open, 0);
      pulse(0, 0, 1, 0); check("en open", gate_open, 1);
      pulse(0, 0, 0, 1); check("dis close", gate_open, 0);
      pulse(0, 0, 1, 0); check("reopen", gate_open, 1);
      pulse(1, 0, 0, 0); pulse(1, 0, 0, 0); pulse(1, 0, 0, 0);
      check("full again", full, 1);
      check("gate holds", gate_open, 1);
      pulse(0, 0, 1, 0); check("en when full", gate_open, 0);
      pulse(0, 1, 1, 0); check("en+down full", gate_open, 1);
      check("en+down count", num_veh, 2);

      cal = 1; step(); cal = 0;
      step(3);
      check("busy before rst", busy, 1);
      reset_n = 0; #2; reset_n = 1;
      check("abort fee", fee, 0);
      check("abort valid", fee_valid, 0);
      check("abort busy", busy, 0);
      check("abort num_veh", num_veh, 0);
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (done) ndone++;
      end
      check("abort no done", ndone, 0);
      check("abort fee hold", fee, 0);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
